// File: rtl/trace_pkg.sv
// trace_pkg
//   Shared layout of one pipeline trace entry {valid, pc, instr}.
//   The flat entry keeps instr in the low XLEN bits, pc above it and the
//   valid flag as the top bit, so a stage register is a single vector.
//   The helper functions give widths/offsets for any XLEN; the typedef
//   and TRACE_W describe the default 32-bit layout.
package trace_pkg;

  localparam int XLEN_DEF = 32;

  function automatic int trace_w(input int xlen);
    return 1 + 2 * xlen;
  endfunction

  function automatic int valid_bit(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return xlen;
  endfunction

  localparam int INSTR_LSB = 0;
  localparam int TRACE_W   = 1 + 2 * XLEN_DEF;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } trace_ent_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous FIFO holding retirement records until the trace sink
//   takes them. The head word is read straight out of the registered
//   storage, so it is available the cycle after the push that wrote it.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (accepted if not full, or full with a pop)
//   push_data   W-bit record
//   pop         remove head (ignored when empty)
//   pop_data    head record, zero when empty
//   full/empty  occupancy flags
module trace_fifo
  import trace_pkg::*;
#(
  parameter int W     = 2 * XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One bit wider than the index: equal indices with differing top bits
  // means the write pointer has lapped the read pointer (full).
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipe_trace_buf.sv
// pipe_trace_buf
//   Carries a {valid, pc, instr} trace tag alongside the pipeline from the
//   decode boundary through STAGES stage registers (stage 0 = E, last = W),
//   each with its own advance and flush. Counts retirements and queues
//   retirement records for the difftest / trace sink.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_pc/in_instr    D-stage trace tag
//   adv[i], flush[i]           per-stage load / clear (flush wins)
//   stg_valid/stg_pc/stg_instr per-stage contents, stage i at [i*XLEN +: XLEN]
//   retire_cnt                 retirements since reset (wraps)
//   rt_valid/rt_ready          retirement FIFO handshake
//   rt_pc/rt_instr             FIFO head record
//   rt_overflow                sticky: a retirement was dropped on a full FIFO
module pipe_trace_buf
  import trace_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [STAGES-1:0]      adv,
  input  logic [STAGES-1:0]      flush,
  output logic [STAGES-1:0]      stg_valid,
  output logic [STAGES*XLEN-1:0] stg_pc,
  output logic [STAGES*XLEN-1:0] stg_instr,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic                   rt_valid,
  input  logic                   rt_ready,
  output logic [XLEN-1:0]        rt_pc,
  output logic [XLEN-1:0]        rt_instr,
  output logic                   rt_overflow
);

  localparam int TW  = trace_w(XLEN);
  localparam int VB  = valid_bit(XLEN);
  localparam int PCL = pc_lsb(XLEN);

  logic [TW-1:0]     d_ent;
  logic [TW-1:0]     pre_w;
  logic              retire;
  logic              rt_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;

  assign d_ent = {in_valid, in_pc, in_instr};

  // Each stage samples its source's pre-edge value, so a downstream stage
  // still picks up the old contents of a stage that is flushed this cycle.
  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      logic [TW-1:0] src;
      logic [TW-1:0] q;

      if (i == 0) begin : g_src_d
        assign src = d_ent;
      end else begin : g_src_prev
        assign src = g_stage[i-1].q;
      end

      always_ff @(posedge clk) begin
        if (rst)           q <= '0;
        else if (flush[i]) q <= '0;
        else if (adv[i])   q <= src;
      end

      assign stg_valid[i]              = q[VB];
      assign stg_pc[i*XLEN +: XLEN]    = q[PCL +: XLEN];
      assign stg_instr[i*XLEN +: XLEN] = q[INSTR_LSB +: XLEN];

      if (i == STAGES-2) begin : g_tap
        assign pre_w = q;
      end
    end
  endgenerate

  // Retirement is the valid entry of the stage before W moving into W.
  assign retire = adv[STAGES-1] & ~flush[STAGES-1] & pre_w[VB];
  assign rt_pop = rt_valid & rt_ready;

  always_ff @(posedge clk) begin
    if (rst)         retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                 rt_overflow <= 1'b0;
    else if (retire & fifo_full & ~rt_pop)   rt_overflow <= 1'b1;
  end

  trace_fifo #(
    .W     (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire),
    .push_data (pre_w[2*XLEN-1:0]),
    .pop       (rt_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rt_valid = ~fifo_empty;
  assign rt_pc    = fifo_head[2*XLEN-1:XLEN];
  assign rt_instr = fifo_head[XLEN-1:0];

endmodule
